// File: rtl/enc4x2_rr_2x_pkg.sv
// Shared types for the registered 4-to-2 request encoder.
// State encoding, index width and the grant decode helper.
package enc4x2_rr_2x_pkg;

  localparam int IDX_W = 2;
  localparam int NREQ  = 4;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic logic [NREQ-1:0] dec2(input idx_t a);
    logic [NREQ-1:0] g;
    g = '0;
    unique case (a)
      2'd0: g = 4'b0001;
      2'd1: g = 4'b0010;
      2'd2: g = 4'b0100;
      2'd3: g = 4'b1000;
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/enc4x2_rr_2x_if.sv
// Request/grant bundle between a requester/consumer and the encoder.
// The encoder sits on the slave side.
interface enc4x2_rr_2x_if;

  logic EN;
  logic D0;
  logic D1;
  logic D2;
  logic D3;
  logic ACK;
  logic A0;
  logic A1;
  logic VLD;
  logic G0;
  logic G1;
  logic G2;
  logic G3;

  modport master (
    output EN, D0, D1, D2, D3, ACK,
    input  A0, A1, VLD, G0, G1, G2, G3
  );

  modport slave (
    input  EN, D0, D1, D2, D3, ACK,
    output A0, A1, VLD, G0, G1, G2, G3
  );

endinterface

// File: rtl/enc4x2_rr_2x_rr_pick4.sv
// Combinational 4-way picker: first set request at or after the
// start pointer (round-robin) or lowest set request (fixed).
import enc4x2_rr_2x_pkg::*;

module rr_pick4 (
  input  logic [3:0] req_i,
  input  idx_t       ptr_i,
  input  logic       rr_en_i,
  output logic       hit_o,
  output idx_t       idx_o
);

  idx_t       base;
  idx_t       off;
  logic [7:0] dbl;
  logic [3:0] rot;

  // Rotate so the start index lands on bit 0, then a plain priority pick.
  always_comb begin
    base  = rr_en_i ? ptr_i : '0;
    dbl   = {req_i, req_i} >> base;
    rot   = dbl[3:0];
    hit_o = |req_i;
    off   = '0;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      rot[3]:  off = 2'd3;
      default: off = 2'd0;
    endcase
    idx_o = base + off;
  end

endmodule

// File: rtl/enc4x2_rr_2x.sv
// Registered 4-to-2 request encoder with hold-until-ACK handshake
// and round-robin or fixed priority selection.
import enc4x2_rr_2x_pkg::*;

module enc4x2_rr_2x #(
  parameter bit RR_EN = 1'b1
) (
  input  logic            CLK,
  input  logic            RSTB,
  enc4x2_rr_2x_if.slave   bus
);

  state_e     state_q;
  idx_t       a_q;
  idx_t       ptr_q;
  idx_t       ptr_d;
  idx_t       ptr_sel;
  logic       vld_q;
  logic [3:0] req;
  logic [3:0] g;
  logic       hit;
  idx_t       idx;

  assign req = {bus.D3, bus.D2, bus.D1, bus.D0} & {4{bus.EN}};

  // In HOLD the next pick must already see the post-ACK pointer.
  assign ptr_d   = a_q + idx_t'(1);
  assign ptr_sel = (state_q == HOLD) ? ptr_d : ptr_q;

  rr_pick4 u_pick (
    .req_i   (req),
    .ptr_i   (ptr_sel),
    .rr_en_i (RR_EN),
    .hit_o   (hit),
    .idx_o   (idx)
  );

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= IDLE;
      a_q     <= '0;
      ptr_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            a_q     <= idx;
            vld_q   <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (bus.ACK) begin
            ptr_q <= ptr_d;
            if (hit) begin
              a_q <= idx;
            end else begin
              vld_q   <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign g = dec2(a_q) & {4{vld_q}};

  assign bus.A0  = a_q[0];
  assign bus.A1  = a_q[1];
  assign bus.VLD = vld_q;
  assign bus.G0  = g[0];
  assign bus.G1  = g[1];
  assign bus.G2  = g[2];
  assign bus.G3  = g[3];

endmodule

// File: tb/tb_enc4x2_rr_2x.sv
// Bench for enc4x2_rr_2x: fixed and round-robin instances share
// stimulus; a queue scoreboard checks every grant against a model.
module tb_enc4x2_rr_2x;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       en_s = 1'b0;
  logic [3:0] d_s = 4'b0000;
  logic       ack_s = 1'b0;

  int nrun = 0;
  int nfail = 0;

  // index 0 = fixed priority instance, 1 = round-robin instance
  bit mvld [2];
  int mptr [2];
  int ma   [2];
  int expq [2][$];
  bit pvld [2];
  bit pack [2];

  always #5 clk = ~clk;

  enc4x2_rr_2x_if if_fx ();
  enc4x2_rr_2x_if if_rr ();

  assign if_fx.EN  = en_s;
  assign if_fx.D0  = d_s[0];
  assign if_fx.D1  = d_s[1];
  assign if_fx.D2  = d_s[2];
  assign if_fx.D3  = d_s[3];
  assign if_fx.ACK = ack_s;
  assign if_rr.EN  = en_s;
  assign if_rr.D0  = d_s[0];
  assign if_rr.D1  = d_s[1];
  assign if_rr.D2  = d_s[2];
  assign if_rr.D3  = d_s[3];
  assign if_rr.ACK = ack_s;

  enc4x2_rr_2x #(.RR_EN(1'b0)) dut_fx (
    .CLK  (clk),
    .RSTB (rstb),
    .bus  (if_fx.slave)
  );

  enc4x2_rr_2x #(.RR_EN(1'b1)) dut_rr (
    .CLK  (clk),
    .RSTB (rstb),
    .bus  (if_rr.slave)
  );

  function automatic logic get_vld(int m);
    return (m == 0) ? if_fx.VLD : if_rr.VLD;
  endfunction

  function automatic logic [1:0] get_a(int m);
    return (m == 0) ? {if_fx.A1, if_fx.A0} : {if_rr.A1, if_rr.A0};
  endfunction

  function automatic logic [3:0] get_g(int m);
    if (m == 0) return {if_fx.G3, if_fx.G2, if_fx.G1, if_fx.G0};
    return {if_rr.G3, if_rr.G2, if_rr.G1, if_rr.G0};
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    nrun++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // First set request scanning upward from start, wrapping mod 4.
  function automatic int pick(input logic [3:0] req, input int start);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (start + k) % 4;
      if (req[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_step(input int m);
    logic [3:0] req;
    int st;
    req = en_s ? d_s : 4'b0000;
    if (!mvld[m]) begin
      if (req != 0) begin
        st = (m == 1) ? mptr[m] : 0;
        ma[m] = pick(req, st);
        mvld[m] = 1'b1;
        expq[m].push_back(ma[m]);
      end
    end else if (ack_s) begin
      mptr[m] = (ma[m] + 1) % 4;
      if (req != 0) begin
        st = (m == 1) ? mptr[m] : 0;
        ma[m] = pick(req, st);
        expq[m].push_back(ma[m]);
      end else begin
        mvld[m] = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mvld[m] = 1'b0;
      mptr[m] = 0;
      ma[m] = 0;
      expq[m].delete();
    end
  endtask

  task automatic cyc(input logic en, input logic [3:0] d, input logic ack);
    en_s = en;
    d_s = d;
    ack_s = ack;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #2;
  endtask

  task automatic chk_reset_outs(input string nm);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_vld%0d", nm, m), 8'(get_vld(m)), 8'd0);
      chk($sformatf("%s_a%0d", nm, m), 8'(get_a(m)), 8'd0);
      chk($sformatf("%s_g%0d", nm, m), 8'(get_g(m)), 8'd0);
    end
  endtask

  // Monitor: per-cycle VLD/G against the model, grants via the queue.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic [3:0] eg;
      eg = mvld[m] ? (4'b0001 << ma[m]) : 4'b0000;
      chk($sformatf("vld_m%0d", m), 8'(get_vld(m)), 8'(mvld[m]));
      chk($sformatf("g_m%0d", m), 8'(get_g(m)), 8'(eg));
      if (get_vld(m) && (!pvld[m] || pack[m])) begin
        if (expq[m].size() == 0) begin
          chk($sformatf("grant_unexpected_m%0d", m), 8'd1, 8'd0);
        end else begin
          int e;
          e = expq[m].pop_front();
          chk($sformatf("grant_m%0d", m), 8'(get_a(m)), 8'(e));
        end
      end
      pvld[m] = get_vld(m);
      pack[m] = ack_s;
    end
  end

  initial begin
    model_reset();
    for (int m = 0; m < 2; m++) begin
      pvld[m] = 1'b0;
      pack[m] = 1'b0;
    end
    #3;
    chk_reset_outs("por");
    @(posedge clk);
    @(posedge clk);
    #2 rstb = 1'b1;

    // single request, hold, then release
    cyc(1'b1, 4'b0100, 1'b0);
    chk("single_a", 8'(get_a(1)), 8'd2);
    chk("single_g", 8'(get_g(1)), 8'b0100);
    repeat (3) cyc(1'b1, 4'b0000, 1'b0);
    chk("hold_a", 8'(get_a(1)), 8'd2);
    chk("hold_vld", 8'(get_vld(1)), 8'd1);
    cyc(1'b1, 4'b0000, 1'b1);
    chk("ack_idle", 8'(get_vld(1)), 8'd0);
    cyc(1'b1, 4'b1111, 1'b0);
    chk("ptr3_rr", 8'(get_a(1)), 8'd3);
    chk("ptr3_fx", 8'(get_a(0)), 8'd0);

    // round robin back-to-back
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 4'b1111, 1'b1);
      chk($sformatf("rr_seq%0d", k), 8'(get_a(1)), 8'(k % 4));
      chk($sformatf("rr_vld%0d", k), 8'(get_vld(1)), 8'd1);
    end
    cyc(1'b1, 4'b0000, 1'b1);

    // fixed priority
    cyc(1'b1, 4'b1010, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 4'b1010, 1'b1);
      chk($sformatf("fx_seq%0d", k), 8'(get_a(0)), 8'd1);
    end
    cyc(1'b1, 4'b1000, 1'b1);
    chk("fx_drop_d1", 8'(get_a(0)), 8'd3);
    cyc(1'b1, 4'b0000, 1'b1);

    // EN gating
    repeat (2) cyc(1'b0, 4'b1111, 1'b0);
    chk("en0_fx", 8'(get_vld(0)), 8'd0);
    chk("en0_rr", 8'(get_vld(1)), 8'd0);
    cyc(1'b1, 4'b1000, 1'b0);
    repeat (2) cyc(1'b0, 4'b1111, 1'b0);
    chk("en_drop_a", 8'(get_a(0)), 8'd3);
    chk("en_drop_vld", 8'(get_vld(0)), 8'd1);
    cyc(1'b0, 4'b1111, 1'b1);
    chk("en_drop_ack", 8'(get_vld(0)), 8'd0);

    // async reset mid-HOLD
    cyc(1'b1, 4'b0100, 1'b0);
    chk("pre_rst_a", 8'(get_a(1)), 8'd2);
    #1 rstb = 1'b0;
    model_reset();
    #1;
    chk_reset_outs("async_rst");
    en_s = 1'b1;
    d_s = 4'b0000;
    ack_s = 1'b0;
    @(posedge clk);
    #2 rstb = 1'b1;
    cyc(1'b1, 4'b0000, 1'b0);
    chk("post_rst_vld", 8'(get_vld(1)), 8'd0);

    // wrap and stray ACK
    cyc(1'b1, 4'b1000, 1'b0);
    chk("wrap_a3", 8'(get_a(1)), 8'd3);
    cyc(1'b1, 4'b0001, 1'b1);
    chk("wrap_a0", 8'(get_a(1)), 8'd0);
    cyc(1'b1, 4'b0000, 1'b1);
    repeat (2) cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b1111, 1'b0);
    chk("stray_rr", 8'(get_a(1)), 8'd1);
    chk("stray_fx", 8'(get_a(0)), 8'd0);
    cyc(1'b1, 4'b0000, 1'b1);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)));
    end
    repeat (3) cyc(1'b1, 4'b0000, 1'b1);
    @(negedge clk);
    #1;
    chk("drain_fx", 8'(expq[0].size()), 8'd0);
    chk("drain_rr", 8'(expq[1].size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule

// File: doc/enc4x2_rr_2x.md
Name: enc4x2_rr_2x

Overview:
- Registered 4-to-2 request encoder: the encode-side counterpart of the 2-to-4 decoder cells in the standard-cell example library.
- Samples four request lines (D0..D3) gated by EN.
- Selects one request by round-robin or fixed priority, presents its 2-bit code (A1:A0) with VLD, and holds it until ACK.
- Used as the verilog_to_laygo example for a small sequential standard-cell block: flops plus nand/inv logic.

Parameters:
- RR_EN, 1: 1 = round-robin priority from pointer PTR; 0 = fixed priority, D0 highest, PTR ignored.

Ports:
- CLK  input  1  clock, rising-edge.
- RSTB  input  1  asynchronous active-low reset.
- EN  input  1  enable; gates new captures only.
- D0..D3  input  1 each  level-sensitive request lines.
- ACK  input  1  consumer accepts the current code.
- A0, A1  output  1 each  registered encoded index of the granted request (A1 = MSB).
- VLD  output  1  registered; code valid.
- G0..G3  output  1 each  one-hot grant = decode(A1:A0) AND VLD.

Behaviour:
- Reset (RSTB=0, asynchronous, no clock needed): A1:A0=00, VLD=0, G0..G3=0000, PTR=00, state IDLE. Release is synchronous to the next CLK rise; no capture occurs on the release edge itself.
- Requests: REQ = {D3,D2,D1,D0} AND EN, evaluated combinationally each cycle.
- Selection:
  - RR_EN=1: search indices PTR, PTR+1, ... mod 4; the first set bit wins.
  - RR_EN=0: lowest set index wins.
- State IDLE (VLD=0):
  - If REQ != 0 at a rising edge: A1:A0 = selected index, VLD = 1, go to HOLD. Latency is 1 cycle from request to VLD.
  - Otherwise, stay in IDLE; outputs unchanged.
- State HOLD (VLD=1):
  - A1:A0 is stable while ACK=0, even if D drops, EN drops, or a higher-priority request appears.
  - On ACK=1 at a rising edge: PTR = granted index + 1 (mod 4, wrap 11->00). This update happens in both modes.
  - Same edge, if REQ (current inputs) != 0: load the next selection using the updated PTR and stay in HOLD. VLD stays 1; this gives back-to-back throughput of 1 grant per cycle.
  - Same edge, if REQ = 0: VLD = 0, go to IDLE. A1:A0 retains its last value; it is don't-care when VLD=0 but must be deterministic.
- ACK while VLD=0: ignored; PTR unchanged.
- A request that stays asserted is re-granted after ACK if it is still the first set bit from the new PTR. With all four held high in RR mode, the grant sequence is 0,1,2,3,0,...
- G outputs: purely combinational from registered A/VLD, so glitch-free relative to CLK. Exactly one G is high when VLD=1.
- RSTB asserted mid-HOLD: outputs clear immediately and PTR returns to 00.

Decomposition:
- Shared package/include: state encoding (IDLE=0, HOLD=1) and the 2-bit index width constant.
- One natural sub-module: rr_pick4 (combinational).
  - Inputs: REQ[3:0], PTR[1:0], RR_EN.
  - Outputs: hit, idx[1:0].
  - Reused by future 8-input variants.
- G decode stays inline.

Test Plan:
- Reset: drive RSTB=0 mid-operation with VLD=1, A=10 -> A=00, VLD=0, G=0000 asynchronously; after release with D=0000, VLD stays 0.
- Single request, RR_EN=1, PTR=00, EN=1, D=0100 -> VLD=1, A1:A0=10, G=0100 one cycle later. Hold ACK=0 for 3 cycles while D=0000: A unchanged. Pulse ACK -> VLD=0 next cycle, PTR=11.
- Round robin: D=1111, ACK tied 1 -> codes 00,01,10,11,00 on consecutive cycles, VLD continuously 1.
- Fixed priority: RR_EN=0, D=1010 with repeated ACK -> code 01 every grant. Drop D1 -> code 11 after the next ACK.
- EN gating: EN=0, D=1111 -> VLD stays 0. EN falls while in HOLD with A=11 -> A stays 11 until ACK, then VLD=0.
- Wrap and stray ACK: grant index 11, ACK with D=0001 -> PTR=00, next code 00. ACK pulse while VLD=0 -> PTR unchanged (verify the next grant order).
